// File: rtl/eda_local_max_scan_pkg.sv
// Shared definitions for the local-maximum scanner.
// Holds the scan FSM state enum, the bit positions of each pixel inside the
// packed 3x3 window word, and the bit positions of each neighbour inside the
// 8-bit neighbour-valid mask produced by eda_border_mask.
package eda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Window slot indices (slot 8 is the most significant pixel of the word).
  localparam int IDX_UL = 8;
  localparam int IDX_U  = 7;
  localparam int IDX_UR = 6;
  localparam int IDX_L  = 5;
  localparam int IDX_C  = 4;
  localparam int IDX_R  = 3;
  localparam int IDX_DL = 2;
  localparam int IDX_D  = 1;
  localparam int IDX_DR = 0;

  // Neighbour-valid mask bits: same order as the window with the centre removed.
  localparam int NB_UL = 7;
  localparam int NB_U  = 6;
  localparam int NB_UR = 5;
  localparam int NB_L  = 4;
  localparam int NB_R  = 3;
  localparam int NB_DL = 2;
  localparam int NB_D  = 1;
  localparam int NB_DR = 0;

endpackage

// File: rtl/eda_local_max_scan_if.sv
// Result stream interface of the local-maximum scanner.
// master (scanner): drives res_valid, res_addr, res_pixel, res_is_max.
// slave (consumer): drives res_ready; a word transfers when valid and ready
// are both high on a rising clock edge.
interface eda_res_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PIXEL_WIDTH = 8
);
  logic                   res_valid;
  logic                   res_ready;
  logic [ADDR_WIDTH-1:0]  res_addr;
  logic [PIXEL_WIDTH-1:0] res_pixel;
  logic                   res_is_max;

  modport master (
    output res_valid,
    output res_addr,
    output res_pixel,
    output res_is_max,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_addr,
    input  res_pixel,
    input  res_is_max,
    output res_ready
  );
endinterface

// File: rtl/eda_border_mask.sv
// Combinational neighbour-valid mask for a pixel at (row, col) in an M x N image.
// Ports: row, col - position of the window centre
//        nb_valid - one bit per neighbour (bit order from eda_pkg NB_*),
//                   1 when that neighbour lies inside the image.
// The mask is derived purely from row/col so that a right-edge pixel never
// sees the first pixel of the next row as its neighbour.
module eda_border_mask
  import eda_pkg::*;
#(
  parameter int M     = 16,
  parameter int N     = 16,
  parameter int ROW_W = (N > 1) ? $clog2(N) : 1,
  parameter int COL_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [7:0]       nb_valid
);

  logic up_ok;
  logic dn_ok;
  logic lf_ok;
  logic rt_ok;

  always_comb begin
    up_ok = (row != '0);
    dn_ok = (row != ROW_W'(N - 1));
    lf_ok = (col != '0);
    rt_ok = (col != COL_W'(M - 1));

    nb_valid        = '0;
    nb_valid[NB_UL] = up_ok & lf_ok;
    nb_valid[NB_U]  = up_ok;
    nb_valid[NB_UR] = up_ok & rt_ok;
    nb_valid[NB_L]  = lf_ok;
    nb_valid[NB_R]  = rt_ok;
    nb_valid[NB_DL] = dn_ok & lf_ok;
    nb_valid[NB_D]  = dn_ok;
    nb_valid[NB_DR] = dn_ok & rt_ok;
  end

endmodule

// File: rtl/eda_local_max_scan.sv
// Row-major local-maximum scanner over an M x N image.
// Ports: clk, reset (sync, active high), start (sampled in IDLE only)
//        center_addr   - registered read address into the window RAM
//        window_values - 3x3 window around center_addr, returned combinationally
//        res           - result stream (valid/ready) carrying addr, pixel, is_max
//        busy, done    - scan in progress / one-cycle completion pulse
//        max_count     - maxima found in the current or last scan
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | stepping center_addr, loading one result per free output slot
// DRAIN | last address loaded, waiting for the final result to be taken
// DONE  | one-cycle done pulse, then back to IDLE
module eda_local_max_scan
  import eda_pkg::*;
#(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M * N),
  parameter int CNT_WIDTH    = $clog2(M * N + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  eda_res_if.master                           res,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_WIDTH-1:0]                max_count
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(M - 1);

  scan_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  center_addr_q, center_addr_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic                   res_valid_q, res_valid_d;
  logic [ADDR_WIDTH-1:0]  res_addr_q, res_addr_d;
  logic [PIXEL_WIDTH-1:0] res_pixel_q, res_pixel_d;
  logic                   res_is_max_q, res_is_max_d;
  logic [CNT_WIDTH-1:0]   max_count_q, max_count_d;

  logic [PIXEL_WIDTH-1:0] w_ul, w_u, w_ur, w_l, w_c, w_r, w_dl, w_d, w_dr;
  logic [7:0]             nb_valid;
  logic                   is_max;
  logic                   load;

  assign w_ul = window_values[IDX_UL*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign w_u  = window_values[IDX_U*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign w_ur = window_values[IDX_UR*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign w_l  = window_values[IDX_L*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign w_c  = window_values[IDX_C*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign w_r  = window_values[IDX_R*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign w_dl = window_values[IDX_DL*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign w_d  = window_values[IDX_D*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign w_dr = window_values[IDX_DR*PIXEL_WIDTH +: PIXEL_WIDTH];

  eda_border_mask #(
    .M     (M),
    .N     (N),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_border_mask (
    .row      (row_q),
    .col      (col_q),
    .nb_valid (nb_valid)
  );

  // Out-of-image neighbours never disqualify the centre; ties still count as a maximum.
  always_comb begin
    is_max = (!nb_valid[NB_UL] || (w_ul <= w_c)) &&
             (!nb_valid[NB_U]  || (w_u  <= w_c)) &&
             (!nb_valid[NB_UR] || (w_ur <= w_c)) &&
             (!nb_valid[NB_L]  || (w_l  <= w_c)) &&
             (!nb_valid[NB_R]  || (w_r  <= w_c)) &&
             (!nb_valid[NB_DL] || (w_dl <= w_c)) &&
             (!nb_valid[NB_D]  || (w_d  <= w_c)) &&
             (!nb_valid[NB_DR] || (w_dr <= w_c));
  end

  always_comb begin
    state_d       = state_q;
    center_addr_d = center_addr_q;
    row_d         = row_q;
    col_d         = col_q;
    res_valid_d   = res_valid_q;
    res_addr_d    = res_addr_q;
    res_pixel_d   = res_pixel_q;
    res_is_max_d  = res_is_max_q;
    max_count_d   = max_count_q;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = SCAN;
          center_addr_d = '0;
          row_d         = '0;
          col_d         = '0;
          max_count_d   = '0;
        end
      end

      SCAN: begin
        load = !res_valid_q || res.res_ready;
        if (load) begin
          res_valid_d  = 1'b1;
          res_addr_d   = center_addr_q;
          res_pixel_d  = w_c;
          res_is_max_d = is_max;
          if (is_max && (max_count_q != '1)) begin
            max_count_d = max_count_q + 1'b1;
          end
          // The last pixel leaves center_addr parked; DRAIN only waits for the hand-off.
          if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d = DRAIN;
          end else begin
            center_addr_d = center_addr_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        if (res.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      center_addr_q <= '0;
      row_q         <= '0;
      col_q         <= '0;
      res_valid_q   <= 1'b0;
      res_addr_q    <= '0;
      res_pixel_q   <= '0;
      res_is_max_q  <= 1'b0;
      max_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      center_addr_q <= center_addr_d;
      row_q         <= row_d;
      col_q         <= col_d;
      res_valid_q   <= res_valid_d;
      res_addr_q    <= res_addr_d;
      res_pixel_q   <= res_pixel_d;
      res_is_max_q  <= res_is_max_d;
      max_count_q   <= max_count_d;
    end
  end

  assign center_addr    = center_addr_q;
  assign res.res_valid  = res_valid_q;
  assign res.res_addr   = res_addr_q;
  assign res.res_pixel  = res_pixel_q;
  assign res.res_is_max = res_is_max_q;
  assign max_count      = max_count_q;
  assign busy           = (state_q == SCAN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Self-checking bench for eda_local_max_scan on a 4x4 image.
// The bench plays the window RAM: it builds the 3x3 window around center_addr
// from its own image, filling out-of-image slots with 0xFF so that any border
// mask error shows up as a wrong is_max.
module tb_eda_local_max_scan;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] center_addr;
  logic [71:0]   window_values;
  logic          busy;
  logic          done;
  logic [CW-1:0] max_count;
  logic          res_ready;
  logic          res_valid;
  logic [AW-1:0] res_addr;
  logic [PW-1:0] res_pixel;
  logic          res_is_max;

  logic [15:0][7:0] img;

  eda_res_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) res_if ();

  assign res_if.res_ready = res_ready;
  assign res_valid        = res_if.res_valid;
  assign res_addr         = res_if.res_addr;
  assign res_pixel        = res_if.res_pixel;
  assign res_is_max       = res_if.res_is_max;

  eda_local_max_scan #(
    .M            (M),
    .N            (N),
    .PIXEL_WIDTH  (PW),
    .WINDOW_WIDTH (9),
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .center_addr   (center_addr),
    .window_values (window_values),
    .res           (res_if),
    .busy          (busy),
    .done          (done),
    .max_count     (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] build_window(input logic [3:0] a, input logic [15:0][7:0] im);
    int r;
    int c;
    int k;
    logic [71:0] w;
    r = int'(a) / 4;
    c = int'(a) % 4;
    k = 8;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((r + dr < 0) || (r + dr > 3) || (c + dc < 0) || (c + dc > 3))
          w[k*8 +: 8] = 8'hFF;
        else
          w[k*8 +: 8] = im[(r + dr) * 4 + c + dc];
        k--;
      end
    end
    return w;
  endfunction

  assign window_values = build_window(center_addr, img);

  function automatic bit model_is_max(input int a, input logic [15:0][7:0] im);
    int r;
    int c;
    bit m;
    r = a / 4;
    c = a % 4;
    m = 1'b1;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 4) &&
            (c + dc >= 0) && (c + dc < 4) && (im[(r + dr) * 4 + c + dc] > im[a]))
          m = 1'b0;
      end
    end
    return m;
  endfunction

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [PW-1:0] exp_pix_q[$];
  logic          exp_max_q[$];
  int            exp_cnt;

  logic [AW-1:0] got_addr_q[$];
  logic [PW-1:0] got_pix_q[$];
  logic          got_max_q[$];
  logic          dut_max[16];

  logic [AW-1:0] hold_addr_q[$];
  logic [AW-1:0] hold_ctr_q[$];
  logic [PW-1:0] hold_pix_q[$];

  int first_valid;
  int done_cnt;
  int done_cycle;
  logic busy_at1;
  logic busy_after;
  bit timed_out;

  task automatic push_expected();
    bit m;
    exp_addr_q.delete();
    exp_pix_q.delete();
    exp_max_q.delete();
    exp_cnt = 0;
    for (int a = 0; a < 16; a++) begin
      m = model_is_max(a, img);
      exp_addr_q.push_back(4'(a));
      exp_pix_q.push_back(img[a]);
      exp_max_q.push_back(m);
      if (m) exp_cnt++;
    end
  endtask

  // Runs one complete scan, collecting every accepted result word.
  task automatic run_scan(input int stall_addr, input int stall_len, input int poke_cycle);
    int i;
    int stall_left;
    bit finished;
    got_addr_q.delete();
    got_pix_q.delete();
    got_max_q.delete();
    hold_addr_q.delete();
    hold_ctr_q.delete();
    hold_pix_q.delete();
    for (int k = 0; k < 16; k++) dut_max[k] = 1'bx;
    first_valid = -1;
    done_cnt    = 0;
    done_cycle  = -1;
    timed_out   = 1'b0;
    busy_at1    = 1'bx;
    busy_after  = 1'bx;
    stall_left  = stall_len;
    @(negedge clk);
    start     = 1'b1;
    res_ready = 1'b1;
    i = 0;
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      i++;
      start = (i == poke_cycle);
      if (i == 1) busy_at1 = busy;
      if (res_valid && first_valid < 0) first_valid = i;
      if (res_valid && int'(res_addr) == stall_addr && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
        hold_addr_q.push_back(res_addr);
        hold_ctr_q.push_back(center_addr);
        hold_pix_q.push_back(res_pixel);
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        got_addr_q.push_back(res_addr);
        got_pix_q.push_back(res_pixel);
        got_max_q.push_back(res_is_max);
        dut_max[res_addr] = res_is_max;
      end
      if (done) begin
        done_cnt++;
        done_cycle = i;
      end
      if (done_cycle >= 0 && i == done_cycle + 1) begin
        busy_after = busy;
        finished = 1'b1;
      end
      if (i >= 200) begin
        timed_out = 1'b1;
        finished = 1'b1;
      end
    end
    start     = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (center_addr !== 4'd0) begin errors++; $display("FAIL reset_center_addr got %0h want 0", center_addr); end
    checks++; if (res_addr !== 4'd0) begin errors++; $display("FAIL reset_res_addr got %0h want 0", res_addr); end
    checks++; if (res_pixel !== 8'd0) begin errors++; $display("FAIL reset_res_pixel got %0h want 0", res_pixel); end
    checks++; if (res_is_max !== 1'b0) begin errors++; $display("FAIL reset_res_is_max got %0b want 0", res_is_max); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (max_count !== 5'd0) begin errors++; $display("FAIL reset_max_count got %0d want 0", max_count); end
    reset = 1'b0;
  endtask

  task automatic test_all_zero();
    for (int a = 0; a < 16; a++) img[a] = 8'd0;
    push_expected();
    run_scan(-1, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout got timeout want done"); end
    checks++; if (got_addr_q.size() != 16) begin errors++; $display("FAIL zero_count got %0d want 16", got_addr_q.size()); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic [PW-1:0] ep, gp;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      ep = exp_pix_q.pop_front();  gp = got_pix_q.pop_front();
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea) begin errors++; $display("FAIL zero_addr got %0d want %0d", ga, ea); end
      checks++; if (gp !== ep || gm !== em) begin errors++; $display("FAIL zero_word addr %0d got pix %0d max %0b want pix %0d max %0b", ea, gp, gm, ep, em); end
    end
    checks++; if (max_count !== 5'd16) begin errors++; $display("FAIL zero_max_count got %0d want 16", max_count); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL zero_first_valid_latency got %0d want 2", first_valid); end
    checks++; if (done_cycle !== 18) begin errors++; $display("FAIL zero_done_cycle got %0d want 18", done_cycle); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL zero_busy_scan got %0b want 1", busy_at1); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_idle got %0b want 0", busy_after); end
  endtask

  task automatic test_single_peak();
    for (int a = 0; a < 16; a++) img[a] = 8'd10;
    img[5] = 8'd200;
    push_expected();
    run_scan(-1, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL peak_timeout got timeout want done"); end
    checks++; if (got_addr_q.size() != 16) begin errors++; $display("FAIL peak_count got %0d want 16", got_addr_q.size()); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic [PW-1:0] ep, gp;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      ep = exp_pix_q.pop_front();  gp = got_pix_q.pop_front();
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gp !== ep || gm !== em) begin errors++; $display("FAIL peak_word got addr %0d pix %0d max %0b want addr %0d pix %0d max %0b", ga, gp, gm, ea, ep, em); end
    end
    checks++; if (max_count !== 5'd8) begin errors++; $display("FAIL peak_max_count got %0d want 8", max_count); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL peak_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_ramp_and_row_wrap();
    for (int a = 0; a < 16; a++) img[a] = 8'(a);
    push_expected();
    run_scan(-1, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL ramp_timeout got timeout want done"); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      void'(exp_pix_q.pop_front()); void'(got_pix_q.pop_front());
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gm !== em) begin errors++; $display("FAIL ramp_word got addr %0d max %0b want addr %0d max %0b", ga, gm, ea, em); end
    end
    checks++; if (max_count !== 5'd1) begin errors++; $display("FAIL ramp_max_count got %0d want 1", max_count); end

    for (int a = 0; a < 16; a++) img[a] = 8'd0;
    img[3] = 8'd50;
    img[4] = 8'd100;
    push_expected();
    run_scan(-1, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout got timeout want done"); end
    checks++; if (dut_max[3] !== 1'b1) begin errors++; $display("FAIL wrap_addr3_is_max got %0b want 1", dut_max[3]); end
    checks++; if (dut_max[4] !== 1'b1) begin errors++; $display("FAIL wrap_addr4_is_max got %0b want 1", dut_max[4]); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      void'(exp_pix_q.pop_front()); void'(got_pix_q.pop_front());
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gm !== em) begin errors++; $display("FAIL wrap_word got addr %0d max %0b want addr %0d max %0b", ga, gm, ea, em); end
    end
    checks++; if (max_count !== 5'(exp_cnt)) begin errors++; $display("FAIL wrap_max_count got %0d want %0d", max_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < 16; a++) img[a] = 8'($urandom_range(0, 255));
    push_expected();
    run_scan(6, 3, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
    checks++; if (hold_addr_q.size() != 3) begin errors++; $display("FAIL bp_stall_cycles got %0d want 3", hold_addr_q.size()); end
    while (hold_addr_q.size() > 0) begin
      logic [AW-1:0] ha, hc;
      logic [PW-1:0] hp;
      ha = hold_addr_q.pop_front();
      hc = hold_ctr_q.pop_front();
      hp = hold_pix_q.pop_front();
      checks++; if (ha !== 4'd6 || hc !== 4'd7 || hp !== img[6]) begin errors++; $display("FAIL bp_hold got addr %0d center %0d pix %0d want addr 6 center 7 pix %0d", ha, hc, hp, img[6]); end
    end
    checks++; if (got_addr_q.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got_addr_q.size()); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic [PW-1:0] ep, gp;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      ep = exp_pix_q.pop_front();  gp = got_pix_q.pop_front();
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gp !== ep || gm !== em) begin errors++; $display("FAIL bp_word got addr %0d pix %0d max %0b want addr %0d pix %0d max %0b", ga, gp, gm, ea, ep, em); end
    end
    checks++; if (max_count !== 5'(exp_cnt)) begin errors++; $display("FAIL bp_max_count got %0d want %0d", max_count, exp_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    for (int a = 0; a < 16; a++) img[a] = 8'd0;
    @(negedge clk);
    start     = 1'b1;
    res_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid && res_addr == 4'd7) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach_addr7 got timeout want res_addr 7"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got valid %0b busy %0b done %0b want 0 0 0", res_valid, busy, done); end
    checks++; if (center_addr !== 4'd0 || res_addr !== 4'd0) begin errors++; $display("FAIL rst_mid_addrs got center %0d res %0d want 0 0", center_addr, res_addr); end
    checks++; if (res_pixel !== 8'd0 || res_is_max !== 1'b0 || max_count !== 5'd0) begin errors++; $display("FAIL rst_mid_data got pix %0d max %0b cnt %0d want 0 0 0", res_pixel, res_is_max, max_count); end

    for (int a = 0; a < 16; a++) img[a] = 8'($urandom_range(0, 255));
    push_expected();
    run_scan(-1, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL rst_rescan_timeout got timeout want done"); end
    checks++; if (got_addr_q.size() != 16) begin errors++; $display("FAIL rst_rescan_count got %0d want 16", got_addr_q.size()); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic [PW-1:0] ep, gp;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      ep = exp_pix_q.pop_front();  gp = got_pix_q.pop_front();
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gp !== ep || gm !== em) begin errors++; $display("FAIL rst_rescan_word got addr %0d pix %0d max %0b want addr %0d pix %0d max %0b", ga, gp, gm, ea, ep, em); end
    end
    checks++; if (max_count !== 5'(exp_cnt)) begin errors++; $display("FAIL rst_rescan_max_count got %0d want %0d", max_count, exp_cnt); end
  endtask

  task automatic test_start_during_scan();
    for (int a = 0; a < 16; a++) img[a] = 8'($urandom_range(0, 255));
    push_expected();
    run_scan(-1, 0, 6);
    checks++; if (timed_out) begin errors++; $display("FAIL poke_timeout got timeout want done"); end
    checks++; if (got_addr_q.size() != 16) begin errors++; $display("FAIL poke_count got %0d want 16", got_addr_q.size()); end
    while (exp_addr_q.size() > 0 && got_addr_q.size() > 0) begin
      logic [AW-1:0] ea, ga;
      logic [PW-1:0] ep, gp;
      logic em, gm;
      ea = exp_addr_q.pop_front(); ga = got_addr_q.pop_front();
      ep = exp_pix_q.pop_front();  gp = got_pix_q.pop_front();
      em = exp_max_q.pop_front();  gm = got_max_q.pop_front();
      checks++; if (ga !== ea || gp !== ep || gm !== em) begin errors++; $display("FAIL poke_word got addr %0d pix %0d max %0b want addr %0d pix %0d max %0b", ga, gp, gm, ea, ep, em); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL poke_done_pulses got %0d want 1", done_cnt); end
    checks++; if (done_cycle !== 18) begin errors++; $display("FAIL poke_done_cycle got %0d want 18", done_cycle); end
    checks++; if (max_count !== 5'(exp_cnt)) begin errors++; $display("FAIL poke_max_count got %0d want %0d", max_count, exp_cnt); end
  endtask

  initial begin
    img       = '0;
    reset     = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    test_reset();
    test_all_zero();
    test_single_peak();
    test_ramp_and_row_wrap();
    test_backpressure();
    test_reset_mid_scan();
    test_start_during_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eda_local_max_scan.md
EDA_LOCAL_MAX_SCAN -- requirements
Module: eda_local_max_scan

Interface
REQ-001 SHALL have parameter M, default 16, meaning image width in pixels (columns per row).
REQ-002 SHALL have parameter N, default 16, meaning image height in rows.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, meaning bits per pixel.
REQ-004 SHALL have parameter WINDOW_WIDTH, default 9, meaning pixels per 3x3 window.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(M*N), meaning pixel address width.
REQ-006 SHALL have parameter CNT_WIDTH, default $clog2(M*N+1), meaning maxima counter width.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-009 SHALL have port start, input, 1, meaning a scan request; sampled only in IDLE.
REQ-010 SHALL have port center_addr, output, ADDR_WIDTH, meaning the registered window-RAM read address.
REQ-011 SHALL have port window_values, input, PIXEL_WIDTH*WINDOW_WIDTH, meaning the combinational window read; order MSB to LSB is upleft, up, upright, left, center, right, downleft, down, downright.
REQ-012 SHALL have port res_valid, output, 1, meaning the result word is valid.
REQ-013 SHALL have port res_ready, input, 1, meaning the consumer accepts the result word.
REQ-014 SHALL have port res_addr, output, ADDR_WIDTH, meaning the address the result describes.
REQ-015 SHALL have port res_pixel, output, PIXEL_WIDTH, meaning the centre pixel value.
REQ-016 SHALL have port res_is_max, output, 1, meaning the centre is a local maximum.
REQ-017 SHALL have ports busy and done, output, 1 each: busy means a scan is in progress; done is a one-cycle completion pulse.
REQ-018 SHALL have port max_count, output, CNT_WIDTH, meaning the number of maxima found in the current or last scan.

Function
REQ-019 SHALL implement FSM states IDLE, SCAN, DRAIN, DONE.
REQ-020 IDLE->SCAN SHALL occur on start=1, clearing center_addr, row, col and max_count to 0.
REQ-021 In SCAN, each cycle in which the output register is empty or is being accepted (res_valid=0 or res_ready=1) SHALL be a load cycle, and a load cycle SHALL register res_addr=center_addr, res_pixel=window centre and res_is_max, set res_valid=1, and advance center_addr.
REQ-022 center_addr SHALL advance row-major with explicit row/col counters, so col wraps from M-1 to 0 and increments row.
REQ-023 When res_valid=1 and res_ready=0, center_addr, row, col and the result fields SHALL hold unchanged, with no loss or duplication of results.
REQ-024 res_is_max SHALL equal 1 iff centre >= every in-bounds neighbour; comparison is unsigned and non-strict.
REQ-025 The neighbour in-bounds mask SHALL be derived from row/col, never from address arithmetic: row 0 masks the up row, row N-1 masks the down row, col 0 masks the left column, col M-1 masks the right column.
REQ-026 max_count SHALL increment by 1 on each load with res_is_max=1 and SHALL never wrap.
REQ-027 After loading address M*N-1, the FSM SHALL go SCAN->DRAIN; DRAIN->DONE SHALL occur when the final result is accepted.
REQ-028 DONE SHALL assert done for exactly one cycle and then return to IDLE; max_count SHALL hold until the next start.
REQ-029 busy SHALL be 1 in SCAN and DRAIN and 0 otherwise.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Throughput SHALL be one result per cycle with res_ready held high; first res_valid SHALL occur 2 cycles after the start cycle.

Reset
REQ-032 On reset=1 the FSM SHALL enter IDLE, and center_addr, res_addr, res_pixel, res_is_max, res_valid, busy, done and max_count SHALL all be 0 on the following cycle.
REQ-033 Reset SHALL take priority over start and over any handshake; reset mid-scan SHALL discard the pending result.

Structure
REQ-034 A shared package eda_pkg SHALL hold the FSM state enum and the window index constants IDX_UL=8 .. IDX_C=4 .. IDX_DR=0.
REQ-035 One sub-module, eda_border_mask, SHALL be combinational and map (row, col, M, N) to an 8-bit neighbour-valid mask.

Verification (M=N=4)
REQ-036 All-zero image, res_ready=1 -> 16 results, addr 0..15 in order, all res_is_max=1, max_count=16, one done pulse.
REQ-037 All pixels 10 except addr5=200 -> is_max=1 only at 3,5,7,11,12,13,14,15; max_count=8.
REQ-038 Pixel value = address -> only addr 15 is_max; addr3=50, addr4=100, rest 0 -> addr3 and addr4 both is_max=1, proving no row wrap.
REQ-039 res_ready low for 3 cycles while res_addr=6 -> res_addr, center_addr and res_pixel held; the next accepted address is 7; 16 results total.
REQ-040 reset pulsed while res_addr=7 -> next cycle all outputs 0; a later start rescans from addr 0 and max_count restarts at 0.
REQ-041 start pulsed during SCAN -> no restart; addresses continue in sequence; one done pulse.
